// File: rtl/ldm_stm_sequencer_module.sv
// Block load/store-multiple sequencer: walks REG_LIST lowest-index first, one word per cycle.
// Optional base writeback state is built only when LDM_STM_WRITEBACK_EN is defined.
module ldm_stm_sequencer_module (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        L,
    input  logic        U,
    input  logic        P,
    input  logic        W,
    input  logic [3:0]  RN_ADDRS,
    input  logic [31:0] BASE_DATA,
    input  logic [15:0] REG_LIST,
    input  logic [31:0] MEM_RD_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [3:0]  ADDRS_RM,
    output logic [3:0]  ADDRS_RD,
    output logic        WRT_ENA,
    output logic [31:0] WRT_DATA,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_WE,
    output logic        MEM_RE
);

`ifdef LDM_STM_WRITEBACK_EN
    typedef enum logic [2:0] {S_IDLE, S_XFER, S_DRAIN, S_WBACK, S_FIN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_XFER, S_DRAIN, S_FIN} state_t;
`endif

    state_t      state_q, state_d, after_xfer;
    logic        l_q, l_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] addr_q, addr_d;
    logic        pend_q, pend_d;
    logic [3:0]  pidx_q, pidx_d;

`ifdef LDM_STM_WRITEBACK_EN
    logic        w_q, w_d;
    logic        wsup_q, wsup_d;
    logic [3:0]  rn_q, rn_d;
    logic [31:0] wbv_q, wbv_d;
`else
    logic        unused_wb;
    assign unused_wb = ^{W, RN_ADDRS};
`endif

    logic [4:0]  cnt;
    logic [31:0] four_n;
    logic [31:0] start_addr;
    logic [3:0]  idx;
    logic        last;

    always_comb begin
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) cnt = cnt + {4'd0, REG_LIST[i]};
    end

    assign four_n = {25'd0, cnt, 2'b00};

    always_comb begin
        case ({U, P})
            2'b10:   start_addr = BASE_DATA;
            2'b11:   start_addr = BASE_DATA + 32'd4;
            2'b00:   start_addr = BASE_DATA - four_n + 32'd4;
            default: start_addr = BASE_DATA - four_n;
        endcase
    end

    // Descending scan so the lowest set bit is the final assignment.
    always_comb begin
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) if (rem_q[i]) idx = 4'(i);
    end

    assign last = (rem_q & (rem_q - 16'd1)) == 16'd0;

`ifdef LDM_STM_WRITEBACK_EN
    assign after_xfer = w_q ? S_WBACK : S_FIN;
`else
    assign after_xfer = S_FIN;
`endif

    always_comb begin
        state_d  = state_q;
        l_d      = l_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        pend_d   = 1'b0;
        pidx_d   = pidx_q;
`ifdef LDM_STM_WRITEBACK_EN
        w_d      = w_q;
        wsup_d   = wsup_q;
        rn_d     = rn_q;
        wbv_d    = wbv_q;
`endif
        BUSY     = (state_q != S_IDLE);
        DONE     = 1'b0;
        ADDRS_RM = 4'd0;
        ADDRS_RD = 4'd0;
        WRT_ENA  = 1'b0;
        WRT_DATA = 32'd0;
        MEM_ADDR = 32'd0;
        MEM_WE   = 1'b0;
        MEM_RE   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    l_d     = L;
                    rem_d   = REG_LIST;
                    addr_d  = start_addr;
`ifdef LDM_STM_WRITEBACK_EN
                    w_d     = W;
                    rn_d    = RN_ADDRS;
                    wsup_d  = L & REG_LIST[RN_ADDRS];
                    wbv_d   = U ? BASE_DATA + four_n : BASE_DATA - four_n;
`endif
                    state_d = (REG_LIST == 16'd0) ? S_FIN : S_XFER;
                end
            end
            S_XFER: begin
                MEM_ADDR = addr_q;
                if (l_q) begin
                    MEM_RE   = 1'b1;
                    WRT_ENA  = pend_q;
                    ADDRS_RD = pend_q ? pidx_q : 4'd0;
                    WRT_DATA = pend_q ? MEM_RD_DATA : 32'd0;
                    pend_d   = 1'b1;
                    pidx_d   = idx;
                end else begin
                    MEM_WE   = 1'b1;
                    ADDRS_RM = idx;
                end
                rem_d  = rem_q & ~(16'd1 << idx);
                addr_d = addr_q + 32'd4;
                if (last) state_d = l_q ? S_DRAIN : after_xfer;
            end
            S_DRAIN: begin
                WRT_ENA  = pend_q;
                ADDRS_RD = pidx_q;
                WRT_DATA = MEM_RD_DATA;
                state_d  = after_xfer;
            end
`ifdef LDM_STM_WRITEBACK_EN
            S_WBACK: begin
                // A loaded base register keeps the loaded value.
                if (!wsup_q) begin
                    WRT_ENA  = 1'b1;
                    ADDRS_RD = rn_q;
                    WRT_DATA = wbv_q;
                end
                state_d = S_FIN;
            end
`endif
            S_FIN: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            l_q     <= 1'b0;
            rem_q   <= 16'd0;
            addr_q  <= 32'd0;
            pend_q  <= 1'b0;
            pidx_q  <= 4'd0;
`ifdef LDM_STM_WRITEBACK_EN
            w_q     <= 1'b0;
            wsup_q  <= 1'b0;
            rn_q    <= 4'd0;
            wbv_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            pidx_q  <= pidx_d;
`ifdef LDM_STM_WRITEBACK_EN
            w_q     <= w_d;
            wsup_q  <= wsup_d;
            rn_q    <= rn_d;
            wbv_q   <= wbv_d;
`endif
        end
    end

endmodule

// File: doc/ldm_stm_sequencer_module.md
LDM_STM_SEQUENCER_MODULE -- requirements
Module: ldm_stm_sequencer_module

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-002 The block SHALL have these ports: CLK  in  1  clock, all state on rising edge.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 START  in  1  one-cycle request; sampled only in IDLE.
REQ-005 L, U, P, W  in  1 each  load (1) / store (0); up (1) / down (0); pre-index (1) / post-index (0); base writeback.
REQ-006 RN_ADDRS  in  4  base register index.
REQ-007 BASE_DATA  in  32  base value, sampled with START.
REQ-008 REG_LIST  in  16  register list, bit i selects register i.
REQ-009 MEM_RD_DATA  in  32  load data, valid the cycle after MEM_RE.
REQ-010 BUSY, DONE  out  1  operation active; one-cycle completion pulse.
REQ-011 ADDRS_RM, ADDRS_RD  out  4  register-file read index (store); write index.
REQ-012 WRT_ENA  out  1  register-file write enable.
REQ-013 WRT_DATA  out  32  register-file write data.
REQ-014 MEM_ADDR  out  32  word address.
REQ-015 MEM_WE, MEM_RE  out  1  memory write strobe; memory read strobe.

Function
REQ-016 The FSM SHALL have states IDLE, XFER, DRAIN, WBACK and FIN; BUSY=1 in every state except IDLE.
REQ-017 In IDLE, START=1 SHALL latch L/U/P/W/RN_ADDRS/BASE_DATA/REG_LIST, set N=popcount(REG_LIST) and go to XFER, or go to FIN if N=0.
REQ-018 The start address SHALL be set by mode: U=1,P=0: base; U=1,P=1: base+4; U=0,P=0: base-4N+4; U=0,P=1: base-4N (mod 2^32).
REQ-019 Each XFER cycle SHALL serve the lowest remaining set bit idx, drive MEM_ADDR=current address, clear idx and add 4 to the address.
REQ-020 On a store, each XFER cycle SHALL drive ADDRS_RM=idx and MEM_WE=1.
REQ-021 On a load, each XFER cycle SHALL drive MEM_RE=1.
REQ-022 On a load, the cycle after each read SHALL drive WRT_ENA=1, ADDRS_RD=previous idx and WRT_DATA=MEM_RD_DATA, overlapping the next read.
REQ-023 After the last XFER, a load SHALL enter DRAIN (final write) and a store SHALL go straight to the next state.
REQ-024 The next state after XFER/DRAIN SHALL be WBACK if W=1, else FIN.
REQ-025 WBACK SHALL write ADDRS_RD=Rn with WRT_DATA=base+4N (U=1) or base-4N (U=0), held for one cycle.
REQ-026 The WBACK write SHALL be suppressed (WRT_ENA=0) when L=1 and Rn is in the list, so the loaded value wins.
REQ-027 FIN SHALL assert DONE=1 for exactly one cycle, then return to IDLE.
REQ-028 START outside IDLE SHALL be ignored.
REQ-029 MEM_WE, MEM_RE and WRT_ENA SHALL never assert in IDLE or FIN, and at most one register write SHALL occur per cycle.
REQ-030 Latency from START to DONE: store N+W+1 cycles; load N+1+W+1 cycles; empty list 1 cycle.

Reset
REQ-031 RST SHALL have priority over all inputs and act at any state, aborting any operation in progress without completing pending writes.
REQ-032 After RST the state SHALL be IDLE and all outputs and latched fields SHALL be 0.

Configuration
REQ-033 Macro LDM_STM_WRITEBACK_EN defined: WBACK state and REQ-024..026 SHALL be implemented.
REQ-034 Macro LDM_STM_WRITEBACK_EN undefined: W SHALL be ignored, WBACK SHALL be removed, and XFER/DRAIN SHALL go directly to FIN.

Verification
REQ-035 Store, REG_LIST=0x000A, BASE=0x100, U=1,P=0,W=1, Rn=0 -> MEM_ADDR 0x100/RM=1, 0x104/RM=3, then write R0=0x108, then DONE.
REQ-036 Load, REG_LIST=0x0015, BASE=0x200, U=0,P=1,W=1, Rn=13 -> reads 0x1F4, 0x1F8, 0x1FC; writes R0, R2, R4 one cycle later each; then R13=0x1F4.
REQ-037 Load, REG_LIST=0x0004, Rn=2, W=1 -> single write R2=MEM_RD_DATA; no WBACK write; DONE.
REQ-038 START with REG_LIST=0 -> DONE one cycle later; no MEM_WE, MEM_RE or WRT_ENA.
REQ-039 RST asserted in the second XFER cycle of a 4-register store -> next cycle IDLE, all outputs 0; a following START runs normally.
REQ-040 Store, REG_LIST=0xFFFF, BASE=0x0, U=1,P=0,W=0 -> 16 MEM_WE cycles at 0x0..0x3C with RM=0..15 in order; DONE after cycle 17.
